// File: rtl/smi_initiator.sv
// SMI bus initiator emulating the Raspberry Pi SMI master. Each 32-bit word is
// carried as four byte cycles (setup / strobe / hold) on SWE (write) or SOE (read).
module smi_initiator #(
  parameter int unsigned P_SETUP   = 2,
  parameter int unsigned P_STROBE  = 4,
  parameter int unsigned P_HOLD    = 2,
  parameter logic [2:0]  P_ADDR_WR = 3'b001,
  parameter logic [2:0]  P_ADDR_RD = 3'b101
) (
  input  logic        i_sys_clk,
  input  logic        swe_and_reset,
  input  logic        i_tx_valid,
  input  logic [31:0] i_tx_data,
  output logic        o_tx_ready,
  input  logic        i_rd_req,
  output logic        o_rx_valid,
  output logic [31:0] o_rx_data,
  output logic [2:0]  o_smi_a,
  output logic        o_smi_soe_se,
  output logic        o_smi_swe_srw,
  output logic [7:0]  o_smi_data_out,
  output logic        o_smi_data_oe,
  input  logic [7:0]  i_smi_data_in,
  output logic        o_busy
);

  localparam int unsigned C_MAX_SS = (P_SETUP > P_STROBE) ? P_SETUP : P_STROBE;
  localparam int unsigned C_MAX    = (C_MAX_SS > P_HOLD) ? C_MAX_SS : P_HOLD;
  localparam int unsigned C_CW     = $clog2(C_MAX) + 1;

  localparam logic C_DIR_WR = 1'b0;
  localparam logic C_DIR_RD = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [C_CW-1:0] r_phase;
  logic [C_CW-1:0] w_phase_len_m1;
  logic            w_phase_last;
  logic [1:0]      r_idx;
  logic            r_dir;
  logic [31:0]     r_tx_word;
  logic [31:0]     r_rx_shift;
  logic [31:0]     r_rx_data;
  logic            r_rx_valid;
  logic            r_tx_ready;
  logic            w_accept_wr;
  logic            w_accept_rd;
  logic [7:0]      w_tx_byte;

  always_comb begin
    case (r_state)
      S_SETUP:  w_phase_len_m1 = C_CW'(P_SETUP - 1);
      S_STROBE: w_phase_len_m1 = C_CW'(P_STROBE - 1);
      S_HOLD:   w_phase_len_m1 = C_CW'(P_HOLD - 1);
      default:  w_phase_len_m1 = '0;
    endcase
  end

  assign w_phase_last = (r_phase == w_phase_len_m1);

  // r_tx_ready is low for the first cycle after reset, so nothing is accepted until it rises.
  assign w_accept_wr = (r_state == S_IDLE) && r_tx_ready && i_tx_valid;
  assign w_accept_rd = (r_state == S_IDLE) && r_tx_ready && !i_tx_valid && i_rd_req;

  always_ff @(posedge i_sys_clk or negedge swe_and_reset) begin
    if (!swe_and_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept_wr || w_accept_rd) begin
          w_state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_phase_last) begin
          w_state_next = S_STROBE;
        end
      end
      S_STROBE: begin
        if (w_phase_last) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_phase_last) begin
          w_state_next = (r_idx == 2'd3) ? S_IDLE : S_SETUP;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge swe_and_reset) begin
    if (!swe_and_reset) begin
      r_phase    <= '0;
      r_idx      <= 2'd0;
      r_dir      <= C_DIR_WR;
      r_tx_word  <= 32'h0;
      r_rx_shift <= 32'h0;
      r_rx_data  <= 32'h0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
    end else begin
      if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + 1'b1;
      end

      r_tx_ready <= (w_state_next == S_IDLE);
      r_rx_valid <= 1'b0;

      if (w_accept_wr) begin
        r_tx_word <= i_tx_data;
        r_dir     <= C_DIR_WR;
        r_idx     <= 2'd0;
      end else if (w_accept_rd) begin
        r_dir     <= C_DIR_RD;
        r_idx     <= 2'd0;
      end

      // Read bytes arrive most-significant first.
      if ((r_state == S_STROBE) && w_phase_last && (r_dir == C_DIR_RD)) begin
        case (r_idx)
          2'd0:    r_rx_shift[31:24] <= i_smi_data_in;
          2'd1:    r_rx_shift[23:16] <= i_smi_data_in;
          2'd2:    r_rx_shift[15:8]  <= i_smi_data_in;
          default: r_rx_shift[7:0]   <= i_smi_data_in;
        endcase
      end

      if ((r_state == S_HOLD) && w_phase_last) begin
        if (r_idx == 2'd3) begin
          if (r_dir == C_DIR_RD) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_rx_shift;
          end
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end
    end
  end

  // Write lane order undoes the responder's {b2,b3,b0,b1} packing.
  always_comb begin
    case (r_idx)
      2'd0:    w_tx_byte = r_tx_word[23:16];
      2'd1:    w_tx_byte = r_tx_word[31:24];
      2'd2:    w_tx_byte = r_tx_word[7:0];
      default: w_tx_byte = r_tx_word[15:8];
    endcase
  end

  always_comb begin
    o_smi_a        = 3'b000;
    o_smi_data_oe  = 1'b0;
    o_smi_data_out = 8'h00;
    o_smi_soe_se   = 1'b1;
    o_smi_swe_srw  = 1'b1;
    o_busy         = (r_state != S_IDLE);
    if (r_state != S_IDLE) begin
      o_smi_a = (r_dir == C_DIR_RD) ? P_ADDR_RD : P_ADDR_WR;
      if (r_dir == C_DIR_WR) begin
        o_smi_data_oe  = 1'b1;
        o_smi_data_out = w_tx_byte;
      end
      if (r_state == S_STROBE) begin
        if (r_dir == C_DIR_RD) begin
          o_smi_soe_se = 1'b0;
        end else begin
          o_smi_swe_srw = 1'b0;
        end
      end
    end
  end

  assign o_tx_ready = r_tx_ready;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;

endmodule

// File: tb/tb_smi_initiator.sv
// Bench for smi_initiator: default timing (instance 0) and fast 1/2/1 timing (instance 1),
// with a bus monitor and responder model driving read bytes.
module tb_smi_initiator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        tx_valid [2];
  logic [31:0] tx_data  [2];
  logic        tx_ready [2];
  logic        rd_req   [2];
  logic        rx_valid [2];
  logic [31:0] rx_data  [2];
  logic [2:0]  smi_a    [2];
  logic        soe      [2];
  logic        swe      [2];
  logic [7:0]  dout     [2];
  logic        doe      [2];
  logic [7:0]  din      [2];
  logic        busy     [2];

  logic [7:0]  wr_bytes  [2][$];
  logic [2:0]  fall_addr [2][$];
  int          fall_cyc  [2][$];
  int          swe_falls [2];
  int          soe_falls [2];
  int          overlap   [2];
  int          rx_pulses [2];
  logic [31:0] resp_word [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int unsigned S = (gi == 0) ? 2 : 1;
      localparam int unsigned T = (gi == 0) ? 4 : 2;
      localparam int unsigned H = (gi == 0) ? 2 : 1;

      smi_initiator #(
        .P_SETUP(S), .P_STROBE(T), .P_HOLD(H),
        .P_ADDR_WR(3'b001), .P_ADDR_RD(3'b101)
      ) u_dut (
        .i_sys_clk(clk),
        .swe_and_reset(rst_n),
        .i_tx_valid(tx_valid[gi]),
        .i_tx_data(tx_data[gi]),
        .o_tx_ready(tx_ready[gi]),
        .i_rd_req(rd_req[gi]),
        .o_rx_valid(rx_valid[gi]),
        .o_rx_data(rx_data[gi]),
        .o_smi_a(smi_a[gi]),
        .o_smi_soe_se(soe[gi]),
        .o_smi_swe_srw(swe[gi]),
        .o_smi_data_out(dout[gi]),
        .o_smi_data_oe(doe[gi]),
        .i_smi_data_in(din[gi]),
        .o_busy(busy[gi])
      );

      logic prev_swe = 1'b1;
      logic prev_soe = 1'b1;
      int   rd_n = 0;

      // Bus monitor plus responder: serves resp_word MSB-first, one byte per SOE fall.
      always @(negedge clk) begin
        if (!swe[gi] && !soe[gi]) overlap[gi] <= overlap[gi] + 1;
        if (prev_swe && !swe[gi]) begin
          swe_falls[gi] <= swe_falls[gi] + 1;
          wr_bytes[gi].push_back(dout[gi]);
          fall_addr[gi].push_back(smi_a[gi]);
          fall_cyc[gi].push_back(cyc);
        end
        if (prev_soe && !soe[gi]) begin
          din[gi] <= 8'(resp_word[gi] >> (24 - 8 * rd_n));
          rd_n <= rd_n + 1;
          soe_falls[gi] <= soe_falls[gi] + 1;
          fall_addr[gi].push_back(smi_a[gi]);
          fall_cyc[gi].push_back(cyc);
        end else if (!busy[gi]) begin
          rd_n <= 0;
        end
        if (rx_valid[gi]) rx_pulses[gi] <= rx_pulses[gi] + 1;
        prev_swe <= swe[gi];
        prev_soe <= soe[gi];
      end
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Byte-cycle period in clocks: SETUP+STROBE+HOLD.
  function automatic int per(input int g);
    return (g == 0) ? 8 : 4;
  endfunction

  // Write lane i carries word bits [sh+7:sh].
  function automatic logic [7:0] wr_lane(input logic [31:0] w, input int i);
    int sh[4] = '{16, 24, 0, 8};
    return 8'(w >> sh[i]);
  endfunction

  task automatic clear_mon(input int g);
    wr_bytes[g].delete();
    fall_addr[g].delete();
    fall_cyc[g].delete();
  endtask

  task automatic wait_idle(input int g, output int nb);
    nb = 0;
    while (busy[g] && nb < 1000) begin
      nb++;
      @(negedge clk);
    end
  endtask

  task automatic do_write(input int g, input logic [31:0] w);
    int nb;
    int s0;
    int o0;
    clear_mon(g);
    s0 = soe_falls[g];
    o0 = overlap[g];
    tx_data[g] = w;
    tx_valid[g] = 1'b1;
    @(negedge clk);
    tx_valid[g] = 1'b0;
    wait_idle(g, nb);
    chk($sformatf("wr%0d_busy_cycles", g), nb, 4 * per(g));
    chk($sformatf("wr%0d_byte_count", g), wr_bytes[g].size(), 4);
    for (int i = 0; i < 4 && i < wr_bytes[g].size(); i++) begin
      chk($sformatf("wr%0d_byte%0d", g, i), 32'(wr_bytes[g][i]), 32'(wr_lane(w, i)));
      chk($sformatf("wr%0d_addr%0d", g, i), 32'(fall_addr[g][i]), 32'h1);
      if (i > 0) chk($sformatf("wr%0d_period%0d", g, i), fall_cyc[g][i] - fall_cyc[g][i-1], per(g));
    end
    if (wr_bytes[g].size() == 4)
      chk($sformatf("wr%0d_loopback_word", g),
          {wr_bytes[g][1], wr_bytes[g][0], wr_bytes[g][3], wr_bytes[g][2]}, w);
    chk($sformatf("wr%0d_no_soe", g), soe_falls[g] - s0, 0);
    chk($sformatf("wr%0d_overlap", g), overlap[g] - o0, 0);
    chk($sformatf("wr%0d_ready_idle", g), 32'(tx_ready[g]), 32'h1);
  endtask

  task automatic do_read(input int g, input logic [31:0] w);
    int nb;
    int s0;
    int f0;
    int o0;
    int p0;
    clear_mon(g);
    resp_word[g] = w;
    s0 = swe_falls[g];
    f0 = soe_falls[g];
    o0 = overlap[g];
    p0 = rx_pulses[g];
    rd_req[g] = 1'b1;
    @(negedge clk);
    rd_req[g] = 1'b0;
    wait_idle(g, nb);
    chk($sformatf("rd%0d_busy_cycles", g), nb, 4 * per(g));
    chk($sformatf("rd%0d_valid_at_idle", g), 32'(rx_valid[g]), 32'h1);
    chk($sformatf("rd%0d_data", g), rx_data[g], w);
    chk($sformatf("rd%0d_soe_falls", g), soe_falls[g] - f0, 4);
    for (int i = 0; i < fall_addr[g].size(); i++) begin
      chk($sformatf("rd%0d_addr%0d", g, i), 32'(fall_addr[g][i]), 32'h5);
      if (i > 0) chk($sformatf("rd%0d_period%0d", g, i), fall_cyc[g][i] - fall_cyc[g][i-1], per(g));
    end
    chk($sformatf("rd%0d_no_swe", g), swe_falls[g] - s0, 0);
    chk($sformatf("rd%0d_overlap", g), overlap[g] - o0, 0);
    @(negedge clk);
    chk($sformatf("rd%0d_valid_one_cycle", g), 32'(rx_valid[g]), 32'h0);
    chk($sformatf("rd%0d_pulse_count", g), rx_pulses[g] - p0, 1);
    chk($sformatf("rd%0d_data_held", g), rx_data[g], w);
  endtask

  initial begin
    int nb;
    int s0;
    int f0;
    int o0;
    int p0;
    int acc;
    int gap;
    int rb;
    logic [31:0] w1;
    logic [31:0] w2;

    for (int g = 0; g < 2; g++) begin
      tx_valid[g] = 1'b0;
      tx_data[g] = 32'h0;
      rd_req[g] = 1'b0;
      resp_word[g] = 32'h0;
    end

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst%0d_outputs", g),
          32'({swe[g], soe[g], smi_a[g], dout[g], doe[g], tx_ready[g], rx_valid[g], busy[g]}),
          32'h18000);
      chk($sformatf("rst%0d_rx_data", g), rx_data[g], 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(tx_ready[0]), 32'h1);
    chk("post_rst_busy", 32'(busy[0]), 32'h0);

    // Directed write and read
    do_write(0, 32'hA1B2C3D4);
    do_read(0, 32'h11223344);

    // Write and read requested together: write first, then read
    w1 = $urandom;
    w2 = $urandom;
    clear_mon(0);
    resp_word[0] = w2;
    s0 = swe_falls[0];
    f0 = soe_falls[0];
    o0 = overlap[0];
    tx_data[0] = w1;
    tx_valid[0] = 1'b1;
    rd_req[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    wait_idle(0, nb);
    chk("both_wr_cycles", nb, 32);
    chk("both_wr_first_swe", swe_falls[0] - s0, 4);
    chk("both_wr_first_no_soe", soe_falls[0] - f0, 0);
    for (int i = 0; i < 4 && i < wr_bytes[0].size(); i++)
      chk($sformatf("both_wr_byte%0d", i), 32'(wr_bytes[0][i]), 32'(wr_lane(w1, i)));
    @(negedge clk);
    rd_req[0] = 1'b0;
    chk("both_rd_started", 32'(busy[0]), 32'h1);
    wait_idle(0, nb);
    chk("both_rd_cycles", nb, 32);
    chk("both_rd_data", rx_data[0], w2);
    chk("both_rd_soe", soe_falls[0] - f0, 4);
    chk("both_overlap", overlap[0] - o0, 0);
    @(negedge clk);

    // Back-to-back writes with tx_valid held
    w1 = $urandom;
    w2 = $urandom;
    clear_mon(0);
    o0 = overlap[0];
    acc = 0;
    nb = 0;
    gap = 0;
    rb = 0;
    tx_data[0] = w1;
    tx_valid[0] = 1'b1;
    for (int c = 0; c < 400; c++) begin
      bit took;
      if (busy[0]) nb++;
      else if (acc == 1) gap++;
      if (tx_ready[0] === busy[0]) rb++;
      took = tx_ready[0] && tx_valid[0];
      if (took) acc++;
      @(negedge clk);
      if (took) begin
        if (acc == 1) tx_data[0] = w2;
        else tx_valid[0] = 1'b0;
      end
      if (acc == 2 && !busy[0]) break;
    end
    tx_valid[0] = 1'b0;
    chk("b2b_accepts", acc, 2);
    chk("b2b_busy_cycles", nb, 64);
    chk("b2b_idle_gap", gap, 1);
    chk("b2b_ready_vs_busy", rb, 0);
    chk("b2b_byte_count", wr_bytes[0].size(), 8);
    for (int i = 0; i < 8 && i < wr_bytes[0].size(); i++)
      chk($sformatf("b2b_byte%0d", i), 32'(wr_bytes[0][i]),
          32'(wr_lane((i < 4) ? w1 : w2, i % 4)));
    chk("b2b_overlap", overlap[0] - o0, 0);

    // Randomized mix of writes and reads
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) do_write(0, $urandom);
      else do_read(0, $urandom);
    end

    // Reset asserted in the middle of a read strobe
    resp_word[0] = $urandom;
    rd_req[0] = 1'b1;
    @(negedge clk);
    rd_req[0] = 1'b0;
    nb = 0;
    while (soe[0] && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk("midrst_reached_strobe", 32'(soe[0]), 32'h0);
    @(negedge clk);
    p0 = rx_pulses[0];
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_strobes_busy_valid", 32'({soe[0], swe[0], busy[0], rx_valid[0]}), 32'hC);
    repeat (3) @(negedge clk);
    chk("midrst_no_rx_pulse", rx_pulses[0] - p0, 0);
    chk("midrst_rx_data", rx_data[0], 32'h0);
    chk("midrst_addr", 32'(smi_a[0]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    do_write(0, $urandom);

    // Fast-timing instance
    do_write(1, 32'hA1B2C3D4);
    do_read(1, $urandom);
    do_write(1, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
